frame_pixel_writer: RTL

//  Producer side of the pixel FIFO that feeds the VGA image block. On request, walks the block

---
 rtl/frame_pixel_writer_pkg.sv | 27 ++
 rtl/frame_pixel_writer_index_ctr.sv | 41 ++++
 rtl/frame_pixel_writer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/frame_pixel_writer_pkg.sv
// -----------------------------------------------------------------------------
// frame_pixel_writer_pkg
//   Shared constants for the frame pixel writer: default block-array geometry
//   of the VGA image block, RGB332 colour codes and a block-count helper.
// -----------------------------------------------------------------------------
package frame_pixel_writer_pkg;

    // Block array geometry of the display (blocks per row / block rows)
    localparam int FPW_BLOCKS_WIDE  = 10;
    localparam int FPW_BLOCKS_HIGH  = 20;
    localparam int FPW_ADDR_W       = 10;
    localparam int FPW_DATA_W       = 8;
    localparam int FPW_CLEAR_CYCLES = 4;

    // RGB332 colour codes used by the image block
    localparam logic [7:0] RGB_BLACK = 8'h00;
    localparam logic [7:0] RGB_RED   = 8'hE0;
    localparam logic [7:0] RGB_GREEN = 8'h1C;
    localparam logic [7:0] RGB_BLUE  = 8'h03;
    localparam logic [7:0] RGB_WHITE = 8'hFF;

    // Number of entries in a blocks_wide x blocks_high array
    function automatic int block_count(input int blocks_wide, input int blocks_high);
        return blocks_wide * blocks_high;
    endfunction

endpackage

// File: rtl/frame_pixel_writer_index_ctr.sv
// -----------------------------------------------------------------------------
// frame_index_ctr
//   Block index counter for the frame pixel writer.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : load 0 (takes priority over inc)
//     inc        : advance index by one
//     idx        : current block index
//     last       : idx equals LAST_IDX
// -----------------------------------------------------------------------------
module frame_index_ctr #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] LAST_IDX = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] idx,
    output logic              last
);

    logic [ADDR_W-1:0] idx_r;

    // Index register: clear loads zero, inc steps by one, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= {ADDR_W{1'b0}};
        end else if (clear) begin
            idx_r <= {ADDR_W{1'b0}};
        end else if (inc) begin
            idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            idx_r <= idx_r;
        end
    end

    assign idx  = idx_r;
    assign last = (idx_r == LAST_IDX);

endmodule

// File: rtl/frame_pixel_writer.sv
// -----------------------------------------------------------------------------
// frame_pixel_writer
//   Streams one frame of block pixels from a sync-read source memory into the
//   VGA pixel FIFO in raster order, after pulsing start_over so the display
//   side rewinds its write index.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     frame_req   : 1-cycle request for one frame (dropped while busy)
//     src_addr    : source read address (always the current block index)
//     src_data    : source read data, valid one cycle after src_addr
//     fifo_full   : FIFO cannot accept a word this cycle
//     fifo_wr_en  : FIFO write strobe (combinational on fifo_full)
//     fifo_din    : FIFO write data (registered pixel)
//     start_over  : clear request to the display side
//     busy        : frame in progress
//     frame_done  : 1-cycle pulse after the last pixel is written
// -----------------------------------------------------------------------------
module frame_pixel_writer
    import frame_pixel_writer_pkg::*;
#(
    parameter int BLOCKS_WIDE  = FPW_BLOCKS_WIDE,
    parameter int BLOCKS_HIGH  = FPW_BLOCKS_HIGH,
    parameter int ADDR_W       = FPW_ADDR_W,
    parameter int DATA_W       = FPW_DATA_W,
    parameter int CLEAR_CYCLES = FPW_CLEAR_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_req,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              start_over,
    output logic              busy,
    output logic              frame_done
);

    localparam int                NUM_BLOCKS = block_count(BLOCKS_WIDE, BLOCKS_HIGH);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_BLOCKS - 1);
    localparam int                CLR_W      = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]  CLR_LAST   = CLR_W'(CLEAR_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic [CLR_W-1:0]  clr_cnt_r;
    logic [DATA_W-1:0] pix_q_r;
    logic [ADDR_W-1:0] idx_s;
    logic              last_s;
    logic              accept_s;
    logic              wr_fire_s;
    logic              ctr_inc_s;

    // A request only counts in IDLE; a write happens only in WRITE with room
    assign accept_s  = (state_r == ST_IDLE) && frame_req;
    assign wr_fire_s = (state_r == ST_WRITE) && !fifo_full;
    // The index stops at the last block so it never leaves 0..N-1
    assign ctr_inc_s = wr_fire_s && !last_s;

    frame_index_ctr #(
        .ADDR_W   (ADDR_W),
        .LAST_IDX (LAST_IDX)
    ) u_index_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept_s),
        .inc   (ctr_inc_s),
        .idx   (idx_s),
        .last  (last_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  begin
                if (frame_req) state_nx_s = ST_CLEAR;
                else           state_nx_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_cnt_r == CLR_LAST) state_nx_s = ST_READ;
                else                       state_nx_s = ST_CLEAR;
            end
            ST_READ:  state_nx_s = ST_LATCH;
            ST_LATCH: state_nx_s = ST_WRITE;
            ST_WRITE: begin
                if (!wr_fire_s)  state_nx_s = ST_WRITE;
                else if (last_s) state_nx_s = ST_DONE;
                else             state_nx_s = ST_READ;
            end
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Clear-phase counter and pixel latch (src_data is valid in LATCH)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_r <= {CLR_W{1'b0}};
            pix_q_r   <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                clr_cnt_r <= {CLR_W{1'b0}};
            end else if (state_r == ST_CLEAR) begin
                clr_cnt_r <= clr_cnt_r + {{(CLR_W-1){1'b0}}, 1'b1};
            end else begin
                clr_cnt_r <= clr_cnt_r;
            end
            if (state_r == ST_LATCH) begin
                pix_q_r <= src_data;
            end else begin
                pix_q_r <= pix_q_r;
            end
        end
    end

    // Output decode from the registered state; wr_en also follows fifo_full
    always_comb begin
        start_over = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        fifo_wr_en = 1'b0;
        case (state_r)
            ST_IDLE:  busy = 1'b0;
            ST_CLEAR: begin
                busy       = 1'b1;
                start_over = 1'b1;
            end
            ST_READ:  busy = 1'b1;
            ST_LATCH: busy = 1'b1;
            ST_WRITE: begin
                busy       = 1'b1;
                fifo_wr_en = wr_fire_s;
            end
            ST_DONE:  begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default:  busy = 1'b0;
        endcase
    end

    assign src_addr = idx_s;
    assign fifo_din = pix_q_r;

endmodule
